// File: rtl/io_capture_fifo.sv
// Snoops CPU I/O writes that match an address window and queues them
// with a timestamp and sequence number behind a first-word-fall-through port.
module io_capture_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16,
  parameter int SEQ_W     = 8,
  parameter int OVERWRITE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     io_we,
  input  logic [ADDR_W-1:0]        io_addr,
  input  logic [DATA_W-1:0]        io_data,
  input  logic [ADDR_W-1:0]        addr_base,
  input  logic [ADDR_W-1:0]        addr_mask,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [TS_W-1:0]          rd_ts,
  output logic [SEQ_W-1:0]         rd_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic [TS_W-1:0]   ts;
    logic [SEQ_W-1:0]  seq;
  } ent_t;

  ent_t              r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [TS_W-1:0]   r_cyc;
  logic [SEQ_W-1:0]  r_seq;
  logic              r_ovf;
  logic [7:0]        r_drop;

  logic w_match;
  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_lose;
  logic w_ovw;
  ent_t w_head;

  assign w_match = enable & io_we &
                   ((io_addr & addr_mask) == (addr_base & addr_mask));
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = w_valid & rd_ready;
  assign w_push  = w_match & (~w_full | w_pop | (OVERWRITE != 0));
  // Full with no pop: the write is lost, or evicts the head in overwrite mode
  assign w_lose  = w_match & w_full & ~w_pop;
  assign w_ovw   = w_lose & (OVERWRITE != 0);

  always_ff @(posedge clk) begin
    if (!reset && !clear && w_push) begin
      r_mem[r_wptr] <= '{io_data, io_addr, r_cyc, r_seq};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_cyc   <= '0;
      r_seq   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      if (enable)
        r_cyc <= r_cyc + TS_W'(1);
      if (w_match)
        r_seq <= r_seq + SEQ_W'(1);
      if (w_push)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop || w_ovw)
        r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop && !w_full)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
      if (w_lose) begin
        r_ovf <= 1'b1;
        if (r_drop != 8'hFF)
          r_drop <= r_drop + 8'd1;
      end
    end
  end

  assign w_head     = r_mem[r_rptr];
  assign rd_valid   = w_valid;
  assign rd_data    = w_valid ? w_head.data : '0;
  assign rd_addr    = w_valid ? w_head.addr : '0;
  assign rd_ts      = w_valid ? w_head.ts   : '0;
  assign rd_seq     = w_valid ? w_head.seq  : '0;
  assign count      = r_count;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;

endmodule
